// File: rtl/div8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div8_seq_ctrl
// Purpose  : 8-bit unsigned restoring divider, one quotient bit per clock,
//            with start/ready request and valid/out_ready result handshakes.
//            Optional macro DIV8_DIVZERO_FAST_EN adds dz_o and a one-step
//            divide-by-zero exit.
// Revision : 1.0 - initial release
// ============================================================================
module div8_seq_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       ready_o,
  input  logic [7:0] dividend_i,
  input  logic [7:0] divisor_i,
  output logic       valid_o,
  input  logic       out_ready_i,
  output logic [7:0] quotient_o,
  output logic [7:0] remainder_o
`ifdef DIV8_DIVZERO_FAST_EN
  ,
  output logic       dz_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_dvd;      // dividend bits shift out, quotient bits shift in
  logic [7:0]  r_dvs;
  logic [7:0]  r_rem;
  logic [2:0]  r_cnt;
  logic [7:0]  r_quo_out;
  logic [7:0]  r_rem_out;
  logic [8:0]  w_shift;
  logic        w_ge;
  logic [7:0]  w_diff;
  logic [7:0]  w_rem_next;
  logic        w_fast;
  logic        w_last;

  // The difference is only used when it fits in 8 bits, so modulo-256 is exact.
  assign w_shift    = {r_rem, r_dvd[7]};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  assign w_diff     = w_shift[7:0] - r_dvs;
  assign w_rem_next = w_ge ? w_diff : w_shift[7:0];

`ifdef DIV8_DIVZERO_FAST_EN
  logic r_dz;
  assign w_fast = (r_dvs == 8'd0);
  assign dz_o   = r_dz;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dz <= 1'b0;
    end else if (r_state == S_IDLE && start_i) begin
      r_dz <= 1'b0;
    end else if (r_state == S_CALC && w_fast) begin
      r_dz <= 1'b1;
    end
  end
`else
  assign w_fast = 1'b0;
`endif

  assign w_last = (r_cnt == 3'd7) || w_fast;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (start_i) w_next = S_CALC;
      end
      S_CALC: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        valid_o = 1'b1;
        if (out_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dvd     <= 8'd0;
      r_dvs     <= 8'd0;
      r_rem     <= 8'd0;
      r_cnt     <= 3'd0;
      r_quo_out <= 8'd0;
      r_rem_out <= 8'd0;
    end else if (r_state == S_IDLE && start_i) begin
      r_dvd <= dividend_i;
      r_dvs <= divisor_i;
      r_rem <= 8'd0;
      r_cnt <= 3'd0;
    end else if (r_state == S_CALC) begin
      r_dvd <= {r_dvd[6:0], w_ge};
      r_rem <= w_rem_next;
      r_cnt <= r_cnt + 3'd1;
      if (w_last) begin
        // In the fast path r_dvd still holds the untouched dividend.
        if (w_fast) begin
          r_quo_out <= 8'hFF;
          r_rem_out <= r_dvd;
        end else begin
          r_quo_out <= {r_dvd[6:0], w_ge};
          r_rem_out <= w_rem_next;
        end
      end
    end
  end

  assign quotient_o  = r_quo_out;
  assign remainder_o = r_rem_out;

endmodule
`default_nettype wire
